// File: rtl/uart_mmio_pkg.sv
// Shared constants, CON register layout and TX FSM encoding for the uart_mmio peripheral.
package uart_mmio_pkg;

    localparam int unsigned BUS_W  = 32;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned CON_W  = 5;

    localparam logic [BUS_W-1:0] ADDR_TXD = 32'h4000_0018;
    localparam logic [BUS_W-1:0] ADDR_RXD = 32'h4000_001C;
    localparam logic [BUS_W-1:0] ADDR_CON = 32'h4000_0020;

    localparam int unsigned CON_TX_IE    = 0;
    localparam int unsigned CON_RX_IE    = 1;
    localparam int unsigned CON_RX_VALID = 2;
    localparam int unsigned CON_TX_READY = 3;
    localparam int unsigned CON_OVERRUN  = 4;

    typedef struct packed {
        logic overrun;
        logic tx_ready;
        logic rx_valid;
        logic rx_ie;
        logic tx_ie;
    } con_t;

    typedef enum logic [1:0] {
        TX_IDLE = 2'd0,
        TX_LOAD = 2'd1,
        TX_BUSY = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_mmio_if.sv
// CPU data-bus interface of the uart_mmio peripheral (single-cycle read/write strobes).
interface uart_mmio_if;
    import uart_mmio_pkg::*;

    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic [BUS_W-1:0] rdata;
    logic             wr;
    logic             rd;

    modport master (output addr, wdata, wr, rd, input rdata);
    modport slave  (input addr, wdata, wr, rd, output rdata);
endinterface

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with wrap-bit pointers; a push into a full FIFO succeeds only alongside a pop.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio.sv
// Memory-mapped UART front end: TX FIFO + send handshake, RX capture, CON register.
// Optional interrupt logic is built when UART_MMIO_IRQ_EN is defined.
module uart_mmio
    import uart_mmio_pkg::*;
#(
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    uart_mmio_if.slave        bus,
    output logic [DATA_W-1:0] TX_DATA,
    output logic              TX_EN,
    output logic [CON_W-1:0]  UART_CON,
    input  logic [DATA_W-1:0] RX_DATA,
    input  logic [1:0]        UART_SIGNAL,
    output logic              irq
);
    logic sel_txd, sel_rxd, sel_con;
    logic wr_txd, wr_con, rd_rxd;

    assign sel_txd = (bus.addr == ADDR_TXD);
    assign sel_rxd = (bus.addr == ADDR_RXD);
    assign sel_con = (bus.addr == ADDR_CON);
    assign wr_txd  = bus.wr & sel_txd;
    assign wr_con  = bus.wr & sel_con;
    assign rd_rxd  = bus.rd & sel_rxd;

    logic unused_wdata;
    assign unused_wdata = ^bus.wdata[BUS_W-1:DATA_W];

    // UART_SIGNAL comes from the sample-clock domain: two flops, plus one more for RX edge detect.
    logic [1:0] sig_meta, sig_sync;
    logic       rx_prev;
    logic       busy_s, rx_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sig_meta <= '0;
            sig_sync <= '0;
            rx_prev  <= 1'b0;
        end else begin
            sig_meta <= UART_SIGNAL;
            sig_sync <= sig_meta;
            rx_prev  <= sig_sync[0];
        end
    end

    assign busy_s  = sig_sync[1];
    assign rx_rise = sig_sync[0] & ~rx_prev;

    // A new byte beats a coinciding RXD read; overrun only when the old byte was never read.
    logic [DATA_W-1:0] rx_buf;
    logic              rx_valid, overrun;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_buf   <= '0;
            rx_valid <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (rx_rise) begin
                rx_buf   <= RX_DATA;
                rx_valid <= 1'b1;
            end else if (rd_rxd) begin
                rx_valid <= 1'b0;
            end
            if (rx_rise & rx_valid & ~rd_rxd)              overrun <= 1'b1;
            else if (wr_con & bus.wdata[CON_OVERRUN])      overrun <= 1'b0;
        end
    end

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, fifo_pop;

    uart_tx_fifo #(
        .DEPTH (TX_DEPTH),
        .WIDTH (DATA_W)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_txd),
        .pop   (fifo_pop),
        .din   (bus.wdata[DATA_W-1:0]),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    tx_state_e         state, state_d;
    logic              tx_en_d;
    logic [DATA_W-1:0] tx_data_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= TX_IDLE;
            TX_EN   <= 1'b0;
            TX_DATA <= '0;
        end else begin
            state   <= state_d;
            TX_EN   <= tx_en_d;
            TX_DATA <= tx_data_d;
        end
    end

    // TX_EN is held from the pop until the sender reports busy; TX_DATA keeps the last byte.
    always_comb begin
        state_d   = state;
        tx_en_d   = TX_EN;
        tx_data_d = TX_DATA;
        fifo_pop  = 1'b0;
        unique case (state)
            TX_IDLE: if (!fifo_empty && !busy_s) begin
                state_d   = TX_LOAD;
                fifo_pop  = 1'b1;
                tx_data_d = fifo_dout;
                tx_en_d   = 1'b1;
            end
            TX_LOAD: if (busy_s) begin
                state_d = TX_BUSY;
                tx_en_d = 1'b0;
            end
            TX_BUSY: if (!busy_s) state_d = TX_IDLE;
            default: begin
                state_d = TX_IDLE;
                tx_en_d = 1'b0;
            end
        endcase
    end

    logic [1:0] irq_en;

`ifdef UART_MMIO_IRQ_EN
    logic irq_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq_en <= '0;
        else if (wr_con) irq_en <= {bus.wdata[CON_RX_IE], bus.wdata[CON_TX_IE]};
    end

    assign irq_d = (irq_en[0] & fifo_empty & (state == TX_IDLE)) | (irq_en[1] & rx_valid);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) irq <= 1'b0;
        else        irq <= irq_d;
    end
`else
    assign irq_en = 2'b00;
    assign irq    = 1'b0;
`endif

    con_t con;
    assign con = '{overrun: overrun, tx_ready: ~fifo_full, rx_valid: rx_valid,
                   rx_ie: irq_en[1], tx_ie: irq_en[0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) UART_CON <= '0;
        else        UART_CON <= con;
    end

    // Read data is combinational from addr/rd and zero outside mapped registers.
    always_comb begin
        bus.rdata = '0;
        if (bus.rd) begin
            if (sel_rxd)      bus.rdata = BUS_W'(rx_buf);
            else if (sel_con) bus.rdata = BUS_W'(con);
        end
    end

endmodule
